// File: rtl/argmax_pkg.sv
// argmax_pkg: shared types and FP16 ordering helpers for the streaming argmax engine
package argmax_pkg;
  localparam int PL_IDX_W = 16;
  localparam int PL_TOK_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_EMIT} state_t;

  typedef struct packed {
    logic [15:0]         key;
    logic [PL_IDX_W-1:0] idx;
    logic [15:0]         val;
    logic [PL_TOK_W-1:0] tok;
    logic                first_grp;
    logic                last_grp;
    logic                valid;
  } pl_t;

  function automatic logic is_nan(input logic [15:0] x);
    return &x[14:10] && |x[9:0];
  endfunction

  // Monotonic unsigned key: larger key means larger FP16 value
  function automatic logic [15:0] fp16_key(input logic [15:0] x);
    return x[15] ? ~x : x | 16'h8000;
  endfunction
endpackage

// File: rtl/argmax_lane_tree.sv
// argmax_lane_tree: pipelined binary reduction of TOUT (key, idx, val) lanes, lower lane wins ties
module argmax_lane_tree
  import argmax_pkg::*;
#(
  parameter int TOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic                     i_first,
  input  logic                     i_last,
  input  logic [PL_TOK_W-1:0]      i_tok,
  input  logic [PL_IDX_W-1:0]      i_base,
  input  logic [TOUT-1:0][15:0]    i_key,
  input  logic [TOUT-1:0][15:0]    i_val,
  output pl_t                      o_pl
);
  localparam int LG = $clog2(TOUT);

  logic [15:0]         r_key [1:TOUT-1];
  logic [15:0]         r_val [1:TOUT-1];
  logic [PL_IDX_W-1:0] r_idx [1:TOUT-1];
  logic [PL_TOK_W+2:0] r_sb  [LG];

  // Heap layout: node n has children 2n and 2n+1; indices >= TOUT are input lanes
  for (genvar n = 1; n < TOUT; n++) begin : g_n
    logic [15:0]         w_ak, w_bk, w_av, w_bv;
    logic [PL_IDX_W-1:0] w_ai, w_bi;
    logic                w_take;
    if (2 * n >= TOUT) begin : g_leaf
      assign w_ak = i_key[2*n-TOUT];
      assign w_bk = i_key[2*n+1-TOUT];
      assign w_av = i_val[2*n-TOUT];
      assign w_bv = i_val[2*n+1-TOUT];
      assign w_ai = i_base + PL_IDX_W'(2 * n - TOUT);
      assign w_bi = i_base + PL_IDX_W'(2 * n + 1 - TOUT);
    end else begin : g_int
      assign w_ak = r_key[2*n];
      assign w_bk = r_key[2*n+1];
      assign w_av = r_val[2*n];
      assign w_bv = r_val[2*n+1];
      assign w_ai = r_idx[2*n];
      assign w_bi = r_idx[2*n+1];
    end
    assign w_take = w_bk > w_ak;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_key[n] <= '0;
        r_val[n] <= '0;
        r_idx[n] <= '0;
      end else begin
        r_key[n] <= w_take ? w_bk : w_ak;
        r_val[n] <= w_take ? w_bv : w_av;
        r_idx[n] <= w_take ? w_bi : w_ai;
      end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < LG; k++) r_sb[k] <= '0;
    end else begin
      r_sb[0] <= {i_valid, i_first, i_last, i_tok};
      for (int k = 1; k < LG; k++) r_sb[k] <= r_sb[k-1];
    end

  assign o_pl = '{key: r_key[1], idx: r_idx[1], val: r_val[1],
                  tok: r_sb[LG-1][PL_TOK_W-1:0],
                  first_grp: r_sb[LG-1][PL_TOK_W+1],
                  last_grp: r_sb[LG-1][PL_TOK_W],
                  valid: r_sb[LG-1][PL_TOK_W+2]};
endmodule

// File: rtl/argmax_topidx_stream.sv
// argmax_topidx_stream: per-token FP16 argmax/argmin over channel-group-major streams
// with a running-best buffer, merge forwarding and in-order result emission.
module argmax_topidx_stream
  import argmax_pkg::*;
#(
  parameter int TOUT      = 32,
  parameter int DAT_DW    = 16,
  parameter int MAX_TOKEN = 128,
  parameter int IDX_W     = 16,
  parameter int TOK_W     = $clog2(MAX_TOKEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic [TOK_W-1:0]       cfg_token,
  input  logic [IDX_W-1:0]       cfg_ch,
  input  logic                   cfg_mode,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOUT*DAT_DW-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOK_W-1:0]       out_token,
  output logic [IDX_W-1:0]       out_idx,
  output logic [DAT_DW-1:0]      out_val
);
  localparam int LG = $clog2(TOUT);
  localparam int CW = IDX_W + LG;
  localparam int AW = $clog2(MAX_TOKEN);
  localparam int EW = 32 + PL_IDX_W;

  state_t                 r_state, w_next;
  logic [TOK_W-1:0]       r_tok, r_t, r_et, r_otok;
  logic [IDX_W-1:0]       r_ch, r_g, r_ngrp, r_oidx;
  logic [15:0]            r_oval;
  logic                   r_mode, r_ov, r_done, r_wv;
  logic [PL_TOK_W-1:0]    r_wtok;
  logic [EW-1:0]          r_rd, r_wd;
  logic [EW-1:0]          r_buf [MAX_TOKEN];
  pl_t                    r_m, w_pl;
  logic [TOUT-1:0][15:0]  w_key;
  logic [CW-1:0]          w_base;
  logic [IDX_W:0]         w_sum;
  logic [EW-1:0]          w_old, w_wd, w_e;
  logic                   w_zero, w_acc, w_last_t, w_last_g, w_fin, w_pop, w_ld, w_last_out;

  assign busy      = r_state != S_IDLE;
  assign in_ready  = r_state == S_ACCUM;
  assign done      = r_done;
  assign out_valid = r_ov;
  assign out_token = r_otok;
  assign out_idx   = r_oidx;
  assign out_val   = r_oval;

  assign w_zero     = cfg_token == '0 || cfg_ch == '0;
  assign w_sum      = {1'b0, cfg_ch} + (IDX_W + 1)'(TOUT - 1);
  assign w_acc      = in_valid && in_ready;
  assign w_last_t   = r_t == r_tok - TOK_W'(1);
  assign w_last_g   = r_g == r_ngrp - IDX_W'(1);
  assign w_base     = {r_g, {LG{1'b0}}};
  assign w_pop      = r_ov && out_ready;
  assign w_last_out = r_otok == r_tok - TOK_W'(1);
  assign w_ld       = r_state == S_EMIT && (!r_ov || out_ready) && r_et != r_tok;

  // NaN and padding lanes get key 0; every real value maps to a nonzero key in either mode
  for (genvar i = 0; i < TOUT; i++) begin : g_l
    logic [15:0] w_x;
    assign w_x = in_data[i*DAT_DW +: 16];
    assign w_key[i] = (w_base + CW'(i) >= CW'(r_ch) || is_nan(w_x)) ? '0
                    : fp16_key(w_x) ^ {16{r_mode}};
  end

  argmax_lane_tree #(.TOUT(TOUT)) u_tree (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(w_acc),
    .i_first(r_g == '0),
    .i_last (w_last_g),
    .i_tok  (r_t),
    .i_base (w_base[IDX_W-1:0]),
    .i_key  (w_key),
    .i_val  (in_data),
    .o_pl   (w_pl)
  );

  // The buffer read for this beat was sampled at the same edge as the previous write
  assign w_old = (r_wv && r_wtok == r_m.tok) ? r_wd : r_rd;
  assign w_wd  = (r_m.first_grp || r_m.key > w_old[EW-1:EW-16]) ? {r_m.key, r_m.idx, r_m.val} : w_old;
  assign w_fin = r_m.valid && r_m.last_grp && r_m.tok == r_tok - TOK_W'(1);
  assign w_e   = r_buf[r_et[AW-1:0]];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (cfg_start && !w_zero) ? S_ACCUM : S_IDLE;
      S_ACCUM: w_next = (w_acc && w_last_t && w_last_g) ? S_DRAIN : S_ACCUM;
      S_DRAIN: w_next = w_fin ? S_EMIT : S_DRAIN;
      S_EMIT:  w_next = (w_pop && w_last_out) ? S_IDLE : S_EMIT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_ff @(posedge clk) begin
    if (r_m.valid) r_buf[r_m.tok[AW-1:0]] <= w_wd;
    r_rd <= r_buf[w_pl.tok[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tok  <= '0;
      r_ch   <= '0;
      r_mode <= 1'b0;
      r_ngrp <= '0;
      r_t    <= '0;
      r_g    <= '0;
      r_et   <= '0;
      r_done <= 1'b0;
      r_m    <= '0;
      r_wv   <= 1'b0;
      r_wtok <= '0;
      r_wd   <= '0;
      r_ov   <= 1'b0;
      r_otok <= '0;
      r_oidx <= '0;
      r_oval <= '0;
    end else begin
      r_done <= (r_state == S_IDLE && cfg_start && w_zero) || (r_state == S_EMIT && w_pop && w_last_out);
      if (r_state == S_IDLE && cfg_start) begin
        r_tok  <= cfg_token;
        r_ch   <= cfg_ch;
        r_mode <= cfg_mode;
        r_ngrp <= IDX_W'(w_sum >> LG);
        r_t    <= '0;
        r_g    <= '0;
        r_et   <= '0;
      end else if (w_acc) begin
        r_t <= w_last_t ? '0 : r_t + TOK_W'(1);
        if (w_last_t) r_g <= r_g + IDX_W'(1);
      end
      r_m    <= w_pl;
      r_wv   <= r_m.valid;
      r_wtok <= r_m.tok;
      r_wd   <= w_wd;
      if (w_ld) begin
        r_ov   <= 1'b1;
        r_otok <= r_et;
        r_oidx <= ~|w_e[EW-1:EW-16] ? '0 : w_e[16 +: PL_IDX_W];
        r_oval <= ~|w_e[EW-1:EW-16] ? 16'h7E00 : w_e[15:0];
        r_et   <= r_et + TOK_W'(1);
      end else if (w_pop) begin
        r_ov <= 1'b0;
      end
    end
endmodule

// File: tb/tb_argmax_topidx_stream.sv
// tb_argmax_topidx_stream: table-driven directed checks plus reset/zero-config sequences
module tb_argmax_topidx_stream;
  localparam int TOUT = 32;
  localparam int TW = 8;
  localparam int IW = 16;

  logic clk = 1'b0, rst_n = 1'b0, cfg_start = 1'b0, cfg_mode = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [TW-1:0] cfg_token = '0;
  logic [IW-1:0] cfg_ch = '0;
  logic [TOUT*16-1:0] in_data = '0;
  logic busy, done, in_ready, out_valid;
  logic [TW-1:0] out_token;
  logic [IW-1:0] out_idx;
  logic [15:0] out_val;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic [3:0]       p;
    logic [7:0]       tok;
    logic [15:0]      ch;
    logic             mode;
    logic             bp;
    logic [3:0][15:0] idx;
    logic [3:0][15:0] val;
  } vec_t;
  vec_t v [9];

  argmax_topidx_stream #(.TOUT(TOUT), .DAT_DW(16), .MAX_TOKEN(128), .IDX_W(IW), .TOK_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_token(cfg_token), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_token(out_token),
    .out_idx(out_idx), .out_val(out_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] gen(input int p, input int t, input int c);
    case (p)
      0: return c == 40 + t ? 16'h3C00 : 16'h3800;
      1: return (c == 5 || c == 37) ? 16'hC000 : 16'h4000;
      2: return c == 32 ? 16'h3800 : c > 32 ? 16'h7BFF : 16'h0000;
      3: return c % 32 == (c / 32 * 3) % 32 ? 16'(32'h3000 + (c / 32) * 256) : 16'h2000;
      4: return c == 105 ? 16'h5000 : c % 32 == c / 32 ? 16'(32'h3000 + (c / 32) * 256) : 16'h2000;
      5: return t == 0 ? (c % 2 == 1 ? 16'hFE00 : 16'h7C01) : c == 7 ? 16'h5000 : 16'h3C00;
      6: return c == 10 + 20 * t ? 16'hBC00 : 16'hB800;
      default: return c == 3 + 11 * t ? 16'h4400 : 16'h4000;
    endcase
  endfunction

  task automatic start(input vec_t r);
    cfg_token = r.tok; cfg_ch = r.ch; cfg_mode = r.mode; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic drive(input vec_t r, input int nmax, output int stalls);
    int n = 0;
    int grps = (int'(r.ch) + TOUT - 1) / TOUT;
    stalls = 0;
    for (int g = 0; g < grps; g++)
      for (int t = 0; t < int'(r.tok); t++) begin
        if (n < nmax) begin
          int w = 0;
          for (int i = 0; i < TOUT; i++) in_data[i*16 +: 16] = gen(int'(r.p), t, g * TOUT + i);
          in_valid = 1'b1;
          // a start pulse while busy must be ignored
          cfg_start = n == 1; cfg_token = n == 1 ? 8'd1 : r.tok; cfg_ch = n == 1 ? 16'd1 : r.ch;
          while (!in_ready && w < 20) begin @(posedge clk); #1; w++; stalls++; end
          @(posedge clk); #1;
          n++;
        end
      end
    in_valid = 1'b0; cfg_start = 1'b0;
  endtask

  task automatic run(input int id, input vec_t r);
    int k = 0, dn = 0, st, extra = 0;
    start(r);
    drive(r, 1 << 20, st);
    chk($sformatf("r%0d_no_stall", id), st, 0);
    for (int c = 0; c < 300 && (k < int'(r.tok) || dn == 0); c++) begin
      logic rdy;
      if (done) dn++;
      if (out_valid && k < int'(r.tok)) begin
        chk($sformatf("r%0d_tok%0d", id, k), out_token, k);
        chk($sformatf("r%0d_idx%0d", id, k), out_idx, r.idx[k]);
        chk($sformatf("r%0d_val%0d", id, k), out_val, r.val[k]);
      end else if (out_valid) extra++;
      rdy = r.bp ? (c % 2 == 1) : 1'b1;
      out_ready = rdy;
      if (out_valid && rdy) k++;
      @(posedge clk); #1;
    end
    for (int c = 0; c < 3; c++) begin
      if (done) dn++;
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk($sformatf("r%0d_results", id), k, r.tok);
    chk($sformatf("r%0d_extra", id), extra, 0);
    chk($sformatf("r%0d_done_pulses", id), dn, 1);
    chk($sformatf("r%0d_idle", id), busy, 0);
  endtask

  initial begin
    int st;
    v[0] = '{p:0, tok:4, ch:64,  mode:0, bp:0, idx:{16'd43, 16'd42, 16'd41, 16'd40}, val:{4{16'h3C00}}};
    v[1] = '{p:1, tok:2, ch:64,  mode:1, bp:0, idx:{16'd0, 16'd0, 16'd5, 16'd5}, val:{4{16'hC000}}};
    v[2] = '{p:1, tok:2, ch:64,  mode:0, bp:0, idx:{4{16'd0}}, val:{4{16'h4000}}};
    v[3] = '{p:2, tok:1, ch:33,  mode:0, bp:0, idx:{16'd0, 16'd0, 16'd0, 16'd32}, val:{4{16'h3800}}};
    v[4] = '{p:3, tok:1, ch:256, mode:0, bp:0, idx:{16'd0, 16'd0, 16'd0, 16'd245}, val:{4{16'h3700}}};
    v[5] = '{p:4, tok:1, ch:256, mode:0, bp:0, idx:{16'd0, 16'd0, 16'd0, 16'd105}, val:{4{16'h5000}}};
    v[6] = '{p:5, tok:2, ch:40,  mode:0, bp:1, idx:{16'd0, 16'd0, 16'd7, 16'd0}, val:{16'h0, 16'h0, 16'h5000, 16'h7E00}};
    v[7] = '{p:6, tok:3, ch:96,  mode:1, bp:0, idx:{16'd0, 16'd50, 16'd30, 16'd10}, val:{4{16'hBC00}}};
    v[8] = '{p:7, tok:2, ch:32,  mode:0, bp:0, idx:{16'd0, 16'd0, 16'd14, 16'd3}, val:{4{16'h4400}}};
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outs", {out_token, out_idx, out_val}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 8; n++) run(n, v[n]);
    cfg_token = 8'd0; cfg_ch = 16'd32; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("zero_tok_done", done, 1);
    chk("zero_tok_busy", busy, 0);
    @(posedge clk); #1;
    chk("zero_tok_done_once", done, 0);
    cfg_token = 8'd2; cfg_ch = 16'd0; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("zero_ch_done", done, 1);
    chk("zero_ch_no_out", out_valid, 0);
    @(posedge clk); #1;
    start(v[0]);
    drive(v[0], 10, st);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run(8, v[8]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
